wrr_packet_arbiter: RTL

//  Weighted round-robin arbiter for NoC router output ports. It locks the grant for a whole

---
 rtl/noc_arb_pkg.sv | 12 +
 rtl/wrr_packet_arbiter_rr_find_first.sv | 31 +++
 rtl/wrr_packet_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and sizing for the NoC output-port packet arbiter.
package noc_arb_pkg;

    localparam int unsigned DEF_NUM_AGENTS = 4;
    localparam int unsigned IDX_W          = $clog2(DEF_NUM_AGENTS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wrr_packet_arbiter_rr_find_first.sv
// Circular priority encoder: first set bit of vec at or after start, wrapping modulo N.
module rr_find_first #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] rotated;

    always_comb begin
        // Doubling the vector turns the circular scan into a linear one from bit 0.
        rotated = {vec, vec} >> start;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && rotated[j]) begin
                found = 1'b1;
                if (int'(start) + int'(j) >= int'(N)) begin
                    idx = W'(int'(start) + int'(j) - int'(N));
                end else begin
                    idx = W'(int'(start) + int'(j));
                end
            end
        end
    end

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter with per-packet grant lock and starvation override.
module wrr_packet_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_AGENTS   = DEF_NUM_AGENTS,
    parameter int unsigned WEIGHT_W     = 3,
    parameter int unsigned STARV_W      = 4,
    parameter int unsigned STARV_THRESH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_AGENTS-1:0]          req,
    input  logic [NUM_AGENTS-1:0]          req_last,
    input  logic [NUM_AGENTS*WEIGHT_W-1:0] weight,
    input  logic                           out_ready,
    output logic [NUM_AGENTS-1:0]          grant,
    output logic [$clog2(NUM_AGENTS)-1:0]  grant_id,
    output logic                           grant_valid,
    output logic                           starv_alert
);

    localparam int unsigned ID_W = $clog2(NUM_AGENTS);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       lock_id_q, lock_id_d;
    logic [WEIGHT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [STARV_W-1:0]    cnt_q [NUM_AGENTS];
    logic [STARV_W-1:0]    cnt_d [NUM_AGENTS];
    logic                  starv_alert_q, starv_alert_d;

    logic [NUM_AGENTS-1:0] starved;
    logic                  s_found, r_found;
    logic [ID_W-1:0]       s_idx, r_idx;
    logic [ID_W-1:0]       winner, cur, cur_next;
    logic [NUM_AGENTS-1:0] cur_oh;
    logic                  have_grant, xfer, tail;
    logic [WEIGHT_W-1:0]   w_sel, eff;
    logic [WEIGHT_W:0]     burst_inc;

    always_comb begin
        for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
            starved[i] = 32'(cnt_q[i]) >= STARV_THRESH;
        end
    end

    rr_find_first #(.N(NUM_AGENTS), .W(ID_W)) u_find_starved (
        .vec   (req & starved),
        .start (ptr_q),
        .found (s_found),
        .idx   (s_idx)
    );

    rr_find_first #(.N(NUM_AGENTS), .W(ID_W)) u_find_req (
        .vec   (req),
        .start (ptr_q),
        .found (r_found),
        .idx   (r_idx)
    );

    always_comb begin
        winner = s_found ? s_idx : r_idx;
        cur    = (state_q == LOCKED) ? lock_id_q : winner;
        cur_oh = '0;
        w_sel  = '0;
        for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
            if (cur == ID_W'(i)) begin
                cur_oh[i] = 1'b1;
                w_sel     = weight[i*WEIGHT_W +: WEIGHT_W];
            end
        end
        have_grant  = rst_n && ((state_q == LOCKED) || r_found);
        grant       = have_grant ? cur_oh : '0;
        grant_id    = have_grant ? cur : '0;
        grant_valid = rst_n && ((state_q == LOCKED) ? |(req & cur_oh) : r_found);
        starv_alert = starv_alert_q;

        xfer      = grant_valid && out_ready;
        tail      = |(req_last & cur_oh);
        eff       = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;
        burst_inc = {1'b0, burst_cnt_q} + (WEIGHT_W + 1)'(1);
        cur_next  = (cur == ID_W'(NUM_AGENTS - 1)) ? '0 : cur + ID_W'(1);

        state_d     = state_q;
        lock_id_d   = lock_id_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (xfer) begin
            if (tail) begin
                state_d = IDLE;
                if (cur == ptr_q && burst_inc < {1'b0, eff}) begin
                    burst_cnt_d = burst_inc[WEIGHT_W-1:0];
                end else begin
                    ptr_d       = cur_next;
                    burst_cnt_d = '0;
                end
            end else if (state_q == IDLE) begin
                state_d   = LOCKED;
                lock_id_d = cur;
            end
        end

        for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
            if (grant[i]) begin
                cnt_d[i] = '0;
            end else if (req[i]) begin
                cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + STARV_W'(1);
            end else begin
                cnt_d[i] = '0;
            end
        end
        starv_alert_d = |starved;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            lock_id_q     <= '0;
            burst_cnt_q   <= '0;
            starv_alert_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            lock_id_q     <= lock_id_d;
            burst_cnt_q   <= burst_cnt_d;
            starv_alert_q <= starv_alert_d;
            for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
